// File: rtl/phivers_plic.sv
// Platform-level interrupt controller for the Phivers PE: edge-triggered gateways,
// per-source priority, threshold, claim/complete and hardware claim on iack_i.
module phivers_plic #(
  parameter int N_SRC  = 8,
  parameter int PRIO_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [3:0]        we_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  input  logic [N_SRC-1:0]  irq_i,
  input  logic              iack_i,
  output logic [N_SRC-1:0]  iack_o,
  output logic              irq_o
);

  localparam logic [7:0] IDX_PEND = 8'h20;
  localparam logic [7:0] IDX_EN   = 8'h40;
  localparam logic [7:0] IDX_TH   = 8'h80;
  localparam logic [7:0] IDX_CLM  = 8'h81;

  logic [PRIO_W-1:0] prio_q [N_SRC];
  logic [PRIO_W-1:0] prio_d [N_SRC];
  logic [N_SRC-1:0]  enable_q, enable_d;
  logic [PRIO_W-1:0] threshold_q, threshold_d;
  logic [N_SRC-1:0]  pending_q, pending_d;
  logic [N_SRC-1:0]  deferred_q, deferred_d;
  logic [N_SRC-1:0]  in_service_q, in_service_d;
  logic [N_SRC-1:0]  irq_q, irq_d;
  logic [N_SRC-1:0]  iack_q, iack_d;
  logic [4:0]        hw_id_q, hw_id_d;
  logic [31:0]       data_q, data_d;
  logic              irq_o_q, irq_o_d;

  logic [7:0]        idx_s;
  logic              rd_s, wr_s, claim_rd_s, cpl_wr_s, do_claim_s, upd_s;
  logic [N_SRC-1:0]  edge_s, elig_s, claim_vec_s, cpl_vec_s;
  logic [4:0]        best_id_s;
  logic [PRIO_W-1:0] best_prio_s, prio_rd_s;
  logic [31:0]       rd_val_s;
  logic              unused_s;

  assign unused_s = ^{addr_i[31:10], addr_i[1:0], data_i};

  // Access decode, eligibility and best-ID arbitration (ties resolve to the lowest ID).
  always_comb begin
    idx_s       = addr_i[9:2];
    rd_s        = en_i & (we_i == 4'd0);
    wr_s        = en_i & (we_i != 4'd0);
    claim_rd_s  = rd_s & (idx_s == IDX_CLM);
    cpl_wr_s    = wr_s & (idx_s == IDX_CLM);
    edge_s      = irq_i & ~irq_q;
    elig_s      = '0;
    best_id_s   = 5'd0;
    best_prio_s = '0;
    upd_s       = 1'b0;
    for (int k = 1; k <= N_SRC; k++) begin
      elig_s[k-1] = pending_q[k-1] & enable_q[k-1] & ~in_service_q[k-1] &
                    (prio_q[k-1] > threshold_q);
      upd_s       = elig_s[k-1] & (prio_q[k-1] > best_prio_s);
      best_id_s   = upd_s ? 5'(k) : best_id_s;
      best_prio_s = upd_s ? prio_q[k-1] : best_prio_s;
    end
    do_claim_s  = (iack_i | (claim_rd_s & (hw_id_q == 5'd0))) & (best_id_s != 5'd0);
    claim_vec_s = '0;
    cpl_vec_s   = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      claim_vec_s[k-1] = do_claim_s & (best_id_s == 5'(k));
      cpl_vec_s[k-1]   = cpl_wr_s & (data_i[4:0] == 5'(k)) & in_service_q[k-1];
    end
  end

  // Gateway state, register writes and hardware-claim latch.
  always_comb begin
    irq_d        = irq_i;
    // An edge landing in the claim cycle sees the source as in service (deferred),
    // one landing in the complete cycle sees it as free (pending).
    in_service_d = (in_service_q & ~cpl_vec_s) | claim_vec_s;
    deferred_d   = (deferred_q & ~cpl_vec_s) | (edge_s & in_service_d);
    pending_d    = (pending_q & ~claim_vec_s) | (edge_s & ~in_service_d) |
                   (cpl_vec_s & deferred_q);
    enable_d     = (wr_s && (idx_s == IDX_EN)) ? data_i[N_SRC:1] : enable_q;
    threshold_d  = (wr_s && (idx_s == IDX_TH)) ? data_i[PRIO_W-1:0] : threshold_q;
    for (int k = 1; k <= N_SRC; k++) begin
      prio_d[k-1] = (wr_s && (idx_s == 8'(k))) ? data_i[PRIO_W-1:0] : prio_q[k-1];
    end
    if (iack_i && (best_id_s != 5'd0)) begin
      hw_id_d = best_id_s;
    end else if (claim_rd_s) begin
      hw_id_d = 5'd0;
    end else begin
      hw_id_d = hw_id_q;
    end
    iack_d  = claim_vec_s;
    irq_o_d = |elig_s;
  end

  // Read-data mux; data_o holds its value between reads.
  always_comb begin
    prio_rd_s = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      prio_rd_s = (idx_s == 8'(k)) ? prio_q[k-1] : prio_rd_s;
    end
    case (idx_s)
      IDX_PEND: rd_val_s = 32'({pending_q, 1'b0});
      IDX_EN:   rd_val_s = 32'({enable_q, 1'b0});
      IDX_TH:   rd_val_s = 32'(threshold_q);
      IDX_CLM:  rd_val_s = (hw_id_q != 5'd0) ? 32'(hw_id_q) : 32'(best_id_s);
      default:  rd_val_s = 32'(prio_rd_s);
    endcase
    data_d = rd_s ? rd_val_s : data_q;
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_q       <= '{default: '0};
      enable_q     <= '0;
      threshold_q  <= '0;
      pending_q    <= '0;
      deferred_q   <= '0;
      in_service_q <= '0;
      irq_q        <= '0;
      iack_q       <= '0;
      hw_id_q      <= 5'd0;
      data_q       <= 32'd0;
      irq_o_q      <= 1'b0;
    end else begin
      prio_q       <= prio_d;
      enable_q     <= enable_d;
      threshold_q  <= threshold_d;
      pending_q    <= pending_d;
      deferred_q   <= deferred_d;
      in_service_q <= in_service_d;
      irq_q        <= irq_d;
      iack_q       <= iack_d;
      hw_id_q      <= hw_id_d;
      data_q       <= data_d;
      irq_o_q      <= irq_o_d;
    end
  end

  assign data_o = data_q;
  assign iack_o = iack_q;
  assign irq_o  = irq_o_q;

endmodule

// File: tb/tb_phivers_plic.sv
// Self-checking bench for phivers_plic: register table plus claim/complete sequences,
// read data checked through an expectation queue.
module tb_phivers_plic;
  localparam int N = 8;

  logic          clk_i  = 1'b0;
  logic          rst_i  = 1'b1;
  logic          en_i   = 1'b0;
  logic [3:0]    we_i   = 4'd0;
  logic [31:0]   addr_i = 32'd0;
  logic [31:0]   data_i = 32'd0;
  logic [31:0]   data_o;
  logic [N-1:0]  irq_i  = '0;
  logic          iack_i = 1'b0;
  logic [N-1:0]  iack_o;
  logic          irq_o;

  int            checks = 0;
  int            errors = 0;
  logic [31:0]   exp_q [$];
  logic          rd_valid_tb = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [11];

  phivers_plic #(.N_SRC(N), .PRIO_W(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .we_i(we_i), .addr_i(addr_i),
    .data_i(data_i), .data_o(data_o), .irq_i(irq_i), .iack_i(iack_i),
    .iack_o(iack_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: a read issued in one cycle is compared on the following falling edge.
  always @(posedge clk_i) rd_valid_tb <= en_i && (we_i == 4'd0);

  always @(negedge clk_i) begin
    if (rd_valid_tb) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_data: unexpected read, got 0x%0h", data_o);
      end else begin
        chk("rd_data", data_o, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    en_i = 1'b1; we_i = 4'hF; addr_i = a; data_i = d;
    tick();
    en_i = 1'b0; we_i = 4'd0;
  endtask

  task automatic bus_rd(input logic [31:0] a, input logic [31:0] e);
    en_i = 1'b1; we_i = 4'd0; addr_i = a;
    exp_q.push_back(e);
    tick();
    en_i = 1'b0;
  endtask

  task automatic pulse(input logic [N-1:0] m);
    irq_i = m;
    tick();
    irq_i = '0;
    tick();
  endtask

  initial begin
    vecs[0]  = '{32'h004, 32'h0000_0005, 1'b1, 32'h5};
    vecs[1]  = '{32'h00C, 32'h0000_00FF, 1'b1, 32'h7};
    vecs[2]  = '{32'h020, 32'h0000_0001, 1'b1, 32'h1};
    vecs[3]  = '{32'h000, 32'h0000_0007, 1'b1, 32'h0};
    vecs[4]  = '{32'h024, 32'h0000_0003, 1'b1, 32'h0};
    vecs[5]  = '{32'h100, 32'hFFFF_FFFF, 1'b1, 32'h1FE};
    vecs[6]  = '{32'h200, 32'h0000_000F, 1'b1, 32'h7};
    vecs[7]  = '{32'h080, 32'h0000_00FF, 1'b1, 32'h0};
    vecs[8]  = '{32'h300, 32'h0000_0005, 1'b1, 32'h0};
    vecs[9]  = '{32'h204, 32'h0000_0000, 1'b0, 32'h0};
    vecs[10] = '{32'h3FC, 32'h0000_0001, 1'b1, 32'h0};

    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_data_o", data_o, 32'h0);
    chk("rst_irq_o", 32'(irq_o), 32'h0);
    chk("rst_iack_o", 32'(iack_o), 32'h0);
    rst_i = 1'b0;
    tick();
    bus_rd(32'h080, 32'h0);

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].wr) bus_wr(vecs[i].addr, vecs[i].wdata);
      bus_rd(vecs[i].addr, vecs[i].exp);
    end
    bus_wr(32'h004, 32'h0); bus_wr(32'h00C, 32'h0); bus_wr(32'h020, 32'h0);
    bus_wr(32'h100, 32'h0); bus_wr(32'h200, 32'h0);

    // Single source: latency, claim, iack pulse, irq_o fall.
    bus_wr(32'h00C, 32'h2); bus_wr(32'h100, 32'h8); bus_wr(32'h200, 32'h0);
    irq_i = 8'h04;
    tick();
    chk("lat_n1_irq_o", 32'(irq_o), 32'h0);
    irq_i = '0;
    tick();
    chk("lat_n2_irq_o", 32'(irq_o), 32'h1);
    bus_rd(32'h080, 32'h8);
    bus_rd(32'h204, 32'h3);
    chk("s1_iack_pulse", 32'(iack_o), 32'h04);
    tick();
    chk("s1_iack_done", 32'(iack_o), 32'h0);
    chk("s1_irq_fall", 32'(irq_o), 32'h0);
    bus_rd(32'h080, 32'h0);
    bus_wr(32'h204, 32'h3);

    // Equal priorities resolve to the lowest ID.
    bus_wr(32'h008, 32'h4); bus_wr(32'h014, 32'h4); bus_wr(32'h100, 32'h24);
    pulse(8'h12);
    bus_rd(32'h204, 32'h2);
    bus_rd(32'h204, 32'h5);
    chk("s2_iack5", 32'(iack_o), 32'h10);
    bus_rd(32'h204, 32'h0);
    bus_wr(32'h204, 32'h2); bus_wr(32'h204, 32'h5); bus_wr(32'h204, 32'h5);
    pulse(8'h12);
    bus_rd(32'h080, 32'h24);
    bus_rd(32'h204, 32'h2); bus_rd(32'h204, 32'h5);
    bus_wr(32'h204, 32'h2); bus_wr(32'h204, 32'h5);

    // Threshold masking.
    bus_wr(32'h004, 32'h4); bus_wr(32'h100, 32'h2); bus_wr(32'h200, 32'h4);
    pulse(8'h01);
    tick();
    chk("s3_masked", 32'(irq_o), 32'h0);
    bus_wr(32'h200, 32'h3);
    chk("s3_not_yet", 32'(irq_o), 32'h0);
    tick();
    chk("s3_rise", 32'(irq_o), 32'h1);
    bus_rd(32'h204, 32'h1);
    bus_wr(32'h204, 32'h1); bus_wr(32'h200, 32'h0);

    // Deferral while in service, and same-cycle claim/complete with an edge.
    bus_wr(32'h010, 32'h5); bus_wr(32'h100, 32'h10);
    pulse(8'h08);
    bus_rd(32'h204, 32'h4);
    pulse(8'h08);
    bus_rd(32'h080, 32'h0);
    bus_wr(32'h204, 32'h4);
    bus_rd(32'h080, 32'h10);
    chk("s4_reassert", 32'(irq_o), 32'h1);
    en_i = 1'b1; we_i = 4'd0; addr_i = 32'h204; irq_i = 8'h08;
    exp_q.push_back(32'h4);
    tick();
    en_i = 1'b0; irq_i = '0;
    bus_rd(32'h080, 32'h0);
    bus_wr(32'h204, 32'h4);
    bus_rd(32'h204, 32'h4);
    en_i = 1'b1; we_i = 4'hF; addr_i = 32'h204; data_i = 32'h4; irq_i = 8'h08;
    tick();
    en_i = 1'b0; we_i = 4'd0; irq_i = '0;
    bus_rd(32'h080, 32'h10);
    bus_rd(32'h204, 32'h4);
    bus_wr(32'h204, 32'h4);
    bus_rd(32'h080, 32'h0);

    // Hardware claim; priority 0 keeps source 8 ineligible.
    bus_wr(32'h018, 32'h6); bus_wr(32'h01C, 32'h2); bus_wr(32'h020, 32'h0);
    bus_wr(32'h100, 32'h1C0);
    pulse(8'hE0);
    iack_i = 1'b1;
    tick();
    iack_i = 1'b0;
    chk("s5_hw_iack", 32'(iack_o), 32'h20);
    bus_rd(32'h204, 32'h6);
    chk("s5_no_claim", 32'(iack_o), 32'h0);
    bus_rd(32'h204, 32'h7);
    chk("s5_sw_iack", 32'(iack_o), 32'h40);
    bus_rd(32'h204, 32'h0);
    bus_rd(32'h080, 32'h100);
    bus_wr(32'h204, 32'h6); bus_wr(32'h204, 32'h7);

    // Asynchronous reset with source 7 in service and irq_o high.
    bus_wr(32'h01C, 32'h3); bus_wr(32'h004, 32'h1); bus_wr(32'h100, 32'h82);
    pulse(8'h40);
    bus_rd(32'h204, 32'h7);
    pulse(8'h01);
    chk("s6_irq_high", 32'(irq_o), 32'h1);
    bus_rd(32'h01C, 32'h3);
    @(negedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    chk("s6_async_irq_o", 32'(irq_o), 32'h0);
    chk("s6_async_data_o", data_o, 32'h0);
    chk("s6_async_iack_o", 32'(iack_o), 32'h0);
    tick();
    rst_i = 1'b0;
    bus_rd(32'h01C, 32'h0);
    bus_rd(32'h004, 32'h0);
    bus_rd(32'h100, 32'h0);
    bus_rd(32'h200, 32'h0);
    bus_rd(32'h080, 32'h0);
    bus_rd(32'h204, 32'h0);
    tick();
    tick();
    chk("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
